// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side drain engine for a synchronous FIFO operated in read-request
//   mode (read data appears one cycle after the read request). Issues FIFO
//   reads, absorbs the one-cycle read latency in a small skid buffer and
//   presents the words as a valid/ready stream at up to one word per cycle.
//
//   Optional feature: define FIFO_RD_STATS_EN to add the o_wcnt delivered-word
//   counter port. Without it the port and counter do not exist.
//
// Ports
//   i_clk        clock
//   i_srst       synchronous reset, active-high
//   i_en         read enable; 0 stops new FIFO reads (an in-flight word lands)
//   o_fifo_rena  FIFO read request
//   i_fifo_rdat  FIFO read data, valid the cycle after an accepted request
//   i_fifo_empt  FIFO empty flag
//   o_tdat       stream data (registered)
//   o_tval       stream valid
//   i_trdy       stream ready
//   o_bcnt       words held in the skid buffer (0..g_BUF)
//   o_wcnt       words delivered, wraps at 2^32 (FIFO_RD_STATS_EN only)
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int g_W   = 72,
    parameter int g_BUF = 2,
    parameter int BW    = $clog2(g_BUF)
) (
    input  logic           i_clk,
    input  logic           i_srst,
    input  logic           i_en,
    output logic           o_fifo_rena,
    input  logic [g_W-1:0] i_fifo_rdat,
    input  logic           i_fifo_empt,
    output logic [g_W-1:0] o_tdat,
    output logic           o_tval,
    input  logic           i_trdy,
    output logic [BW:0]    o_bcnt
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]    o_wcnt
`endif
);

    localparam logic [BW+1:0] RESV_MAX = (BW+2)'(g_BUF);

    logic [g_W-1:0] mem [g_BUF];

    logic [BW-1:0]  head_reg;
    logic [BW-1:0]  head_next;
    logic [BW-1:0]  tail_reg;
    logic [BW:0]    bcnt_reg;
    logic [BW:0]    bcnt_next;
    logic [BW:0]    left_after_pop;
    logic           rd_pend_reg;
    logic [g_W-1:0] tdat_reg;
    logic [g_W-1:0] tdat_next;
    logic           pop;
    logic           capture;
    logic [BW+1:0]  resv;

    assign pop     = o_tval & i_trdy;
    assign capture = rd_pend_reg;

    // Credits already committed: words buffered plus the word in flight.
    assign resv = {1'b0, bcnt_reg} + {{(BW+1){1'b0}}, rd_pend_reg};

    // A full reservation may still issue when a word leaves this cycle; the
    // new word lands next cycle into the slot freed now.
    assign o_fifo_rena = ~i_srst & i_en & ~i_fifo_empt &
                         ((resv < RESV_MAX) | ((resv == RESV_MAX) & pop));

    always_comb begin
        head_next      = head_reg + BW'(pop);
        left_after_pop = bcnt_reg - (BW+1)'(pop);

        bcnt_next = bcnt_reg;
        if (capture && !pop) begin
            bcnt_next = bcnt_reg + 1'b1;
        end else if (pop && !capture) begin
            bcnt_next = bcnt_reg - 1'b1;
        end

        // The output register always mirrors the next head entry. When the
        // buffer would otherwise be empty, the word being captured right now
        // becomes the head, so bypass the memory for that one case.
        if (capture && (left_after_pop == '0)) begin
            tdat_next = i_fifo_rdat;
        end else begin
            tdat_next = mem[head_next];
        end
    end

    // Buffer storage: no reset needed, occupancy tracking qualifies contents.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            mem[tail_reg] <= i_fifo_rdat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            bcnt_reg    <= '0;
            rd_pend_reg <= 1'b0;
            tdat_reg    <= '0;
        end else begin
            rd_pend_reg <= o_fifo_rena;
            head_reg    <= head_next;
            bcnt_reg    <= bcnt_next;
            tdat_reg    <= tdat_next;
            if (capture) begin
                tail_reg <= tail_reg + BW'(1);
            end
        end
    end

    assign o_tval = (bcnt_reg != '0);
    assign o_tdat = tdat_reg;
    assign o_bcnt = bcnt_reg;

`ifdef FIFO_RD_STATS_EN
    logic [31:0] wcnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            wcnt_reg <= '0;
        end else if (pop) begin
            wcnt_reg <= wcnt_reg + 32'd1;
        end
    end

    assign o_wcnt = wcnt_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
//   Self-checking bench for fifo_rd_stream. A queue-based FIFO feeds the DUT;
//   a scoreboard of words in write order plus issued/delivered counters give
//   the expected occupancy, valid, read-request and data every cycle.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int W   = 72;
    localparam int BUF = 2;
    localparam int BW  = $clog2(BUF);

    logic          clk  = 1'b0;
    logic          srst = 1'b1;
    logic          en   = 1'b0;
    logic          trdy = 1'b0;
    logic          empt;
    logic          rena;
    logic          tval;
    logic [W-1:0]  rdat = '0;
    logic [W-1:0]  tdat;
    logic [BW:0]   bcnt;
`ifdef FIFO_RD_STATS_EN
    logic [31:0]   wcnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .g_W   (W),
        .g_BUF (BUF)
    ) dut (
        .i_clk       (clk),
        .i_srst      (srst),
        .i_en        (en),
        .o_fifo_rena (rena),
        .i_fifo_rdat (rdat),
        .i_fifo_empt (empt),
        .o_tdat      (tdat),
        .o_tval      (tval),
        .i_trdy      (trdy),
        .o_bcnt      (bcnt)
`ifdef FIFO_RD_STATS_EN
        ,
        .o_wcnt      (wcnt)
`endif
    );

    // Source FIFO model: one-cycle registered read data on request.
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           push_cnt = 0;
    int           pop_cnt  = 0;

    assign empt = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (rena && fifo_q.size() > 0) begin
            rdat    <= fifo_q.pop_front();
            pop_cnt <= pop_cnt + 1;
        end
    end

    int           errors    = 0;
    int           checks    = 0;
    int           iss_c1    = 0;   // reads issued through the previous cycle
    int           iss_c2    = 0;   // reads issued through two cycles ago
    int           delivered = 0;   // words accepted by the consumer
    int           npop      = 0;
    logic [31:0]  wcnt_exp  = '0;
    logic         rst_prev  = 1'b1;
    bit           seq_mode  = 1'b1;
    logic [W-1:0] seq_val   = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // read request, then advance the model.
    task automatic step(input logic rdy, input logic en_i, input logic rst, input int npush);
        logic         pop;
        logic         exp_rena;
        int           held;
        int           outst;
        logic [95:0]  r;
        logic [W-1:0] w;
        @(negedge clk);
        held = iss_c2 - delivered;
        chk("bcnt", 128'(bcnt), 128'(held));
        chk("tval", 128'(tval), 128'(held != 0));
        if (rst_prev) begin
            chk("tdat_rst", 128'(tdat), 128'(0));
        end else if (held != 0 && exp_q.size() > 0) begin
            chk("tdat", 128'(tdat), 128'(exp_q[0]));
        end
`ifdef FIFO_RD_STATS_EN
        chk("wcnt", 128'(wcnt), 128'(wcnt_exp));
`endif
        srst = rst;
        trdy = rst ? 1'b0 : rdy;
        en   = en_i;
        for (int k = 0; k < npush; k++) begin
            if (seq_mode) begin
                w       = seq_val;
                seq_val = seq_val + 1'b1;
            end else begin
                r = {$urandom, $urandom, $urandom};
                w = r[W-1:0];
            end
            fifo_q.push_back(w);
            exp_q.push_back(w);
            push_cnt++;
        end
        #1;
        pop      = (held != 0) && trdy;
        outst    = iss_c1 - delivered;
        exp_rena = !rst && en && !empt && ((outst < BUF) || (outst == BUF && pop));
        chk("rena", 128'(rena), 128'(exp_rena));
        if (pop && exp_q.size() > 0) begin
            $display("pop %0d data=%0h", npop, exp_q[0]);
            void'(exp_q.pop_front());
            delivered++;
            npop++;
            wcnt_exp = wcnt_exp + 32'd1;
        end
        if (rst) begin
            // Buffered and in-flight words are lost on reset.
            for (int k = 0; k < iss_c1 - delivered; k++) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            iss_c1    = 0;
            iss_c2    = 0;
            delivered = 0;
            wcnt_exp  = '0;
        end else begin
            iss_c2 = iss_c1;
            iss_c1 = iss_c1 + (rena ? 1 : 0);
        end
        rst_prev = rst;
    endtask

    localparam logic [3:0] RDY_PAT = 4'b1001;

    initial begin
        logic [3:0] pat;
        pat = RDY_PAT;

        // Reset held three cycles with a non-empty FIFO.
        step(0, 1, 1, 3);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);

        // Drain, then a lone word into an empty FIFO.
        repeat (8) step(1, 1, 0, 0);
        seq_val = 72'h01;
        step(1, 1, 0, 1);
        repeat (6) step(1, 1, 0, 0);

        // Throughput: 64 preloaded words, consumer always ready.
        seq_val = '0;
        step(1, 0, 0, 64);
        repeat (70) step(1, 1, 0, 0);

        // Back-pressure: 16 words, ready pattern 1,0,0,1.
        seq_val = '0;
        step(0, 0, 0, 16);
        for (int i = 0; i < 64; i++) step(pat[3 - (i % 4)], 1, 0, 0);

        // Enable dropped mid-stream, then drain to empty.
        seq_mode = 1'b0;
        step(1, 0, 0, 20);
        for (int i = 0; i < 40; i++) step(1, !(i >= 5 && i < 12), 0, 0);

        // Reset with a full-ish buffer and a read in flight, then 10+ pops.
        step(0, 1, 0, 10);
        repeat (4) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 1, 0);
        step(1, 1, 0, 6);
        repeat (20) step(1, 1, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Final drain: every written word must have come out.
        repeat (400) step(1, 1, 0, 0);
        chk("drain_exp", 128'(exp_q.size()), 128'(0));
        chk("drain_fifo", 128'(fifo_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
